// File: rtl/ctrl_pkg.sv
// Shared definitions for the 8-bit processor control unit: opcodes, ALU codes,
// sequencer states and the decoded-instruction record.
package ctrl_pkg;

    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_BEQZ = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALTED
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_LDI,
        CLS_BEQZ,
        CLS_JMP,
        CLS_HALT,
        CLS_ILLEGAL
    } instr_class_t;

    typedef struct packed {
        instr_class_t cls;
        logic [2:0]   alu_op;
        logic [2:0]   rd;
        logic [2:0]   rs1;
        logic [2:0]   rs2;
        logic [7:0]   imm;
    } decoded_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational split of a 16-bit instruction word into register fields,
// immediate/target and instruction class.
module instr_decoder
    import ctrl_pkg::*;
(
    input  logic [15:0] instr,
    output decoded_t    dec
);

    always_comb begin
        dec        = '0;
        dec.alu_op = instr[14:12];
        dec.rd     = instr[11:9];
        dec.rs1    = instr[8:6];
        dec.rs2    = instr[5:3];
        dec.imm    = instr[7:0];
        case (instr[15:12])
            OP_LDI:  dec.cls = CLS_LDI;
            OP_BEQZ: begin
                dec.cls = CLS_BEQZ;
                // BEQZ tests the register in the rd slot, read through port A
                dec.rs1 = instr[11:9];
            end
            OP_JMP:  dec.cls = CLS_JMP;
            OP_HALT: dec.cls = CLS_HALT;
            4'hB, 4'hC, 4'hD, 4'hE: dec.cls = CLS_ILLEGAL;
            default: dec.cls = CLS_RTYPE;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute/writeback sequencer driving the ALU and register file.
// Define CTRL_ILLEGAL_TRAP_EN to trap opcodes B-E (sticky illegal + HALTED); otherwise they run as NOPs.
module control_unit
    import ctrl_pkg::*;
#(
    parameter int                    PC_WIDTH   = 8,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [15:0]           imem_rdata,
    input  logic                  imem_valid,
    output logic [2:0]            rf_raddr1,
    output logic [2:0]            rf_raddr2,
    input  logic [DATA_WIDTH-1:0] rf_rdata1,
    input  logic [DATA_WIDTH-1:0] rf_rdata2,
    output logic                  rf_we,
    output logic [2:0]            rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [2:0]            alu_control,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    output logic                  zero_flag,
    output logic                  halted,
    output logic                  illegal
);

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [15:0]           ir_q, ir_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  zero_flag_q, zero_flag_d;
    decoded_t              dec;

    instr_decoder u_decoder (
        .instr (ir_q),
        .dec   (dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_q       <= '0;
            zero_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_q       <= res_d;
            zero_flag_q <= zero_flag_d;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    logic trap;

    assign trap = (dec.cls == CLS_ILLEGAL);

    always_comb begin
        illegal_d = illegal_q;
        if (state_q == ST_DECODE && trap) illegal_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) illegal_q <= 1'b0;
        else       illegal_q <= illegal_d;
    end

    assign illegal = illegal_q;
`else
    logic trap;

    assign trap    = 1'b0;
    assign illegal = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (run) state_d = ST_FETCH;
            ST_FETCH:     if (imem_valid) state_d = ST_DECODE;
            ST_DECODE:    state_d = (dec.cls == CLS_HALT || trap) ? ST_HALTED : ST_EXECUTE;
            ST_EXECUTE:   state_d = ST_WRITEBACK;
            ST_WRITEBACK: state_d = ST_FETCH;
            ST_HALTED:    state_d = ST_HALTED;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        ir_d        = ir_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        res_d       = res_q;
        zero_flag_d = zero_flag_q;
        case (state_q)
            ST_FETCH:  if (imem_valid) ir_d = imem_rdata;
            ST_DECODE: begin
                op_a_d = rf_rdata1;
                op_b_d = rf_rdata2;
            end
            ST_EXECUTE: begin
                res_d = alu_result;
                // JMP and the illegal-as-NOP case must not disturb the flag
                if (dec.cls == CLS_RTYPE || dec.cls == CLS_LDI || dec.cls == CLS_BEQZ)
                    zero_flag_d = alu_zero;
            end
            ST_WRITEBACK: begin
                if (dec.cls == CLS_JMP)
                    pc_d = PC_WIDTH'(dec.imm);
                else if (dec.cls == CLS_BEQZ && zero_flag_q)
                    pc_d = PC_WIDTH'(dec.imm);
                else
                    pc_d = pc_q + PC_WIDTH'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        imem_req    = (state_q == ST_FETCH);
        imem_addr   = pc_q;
        rf_raddr1   = '0;
        rf_raddr2   = '0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        alu_a       = '0;
        alu_b       = '0;
        alu_control = ALU_ADD;
        halted      = (state_q == ST_HALTED);
        zero_flag   = zero_flag_q;
        case (state_q)
            ST_DECODE: begin
                rf_raddr1 = dec.rs1;
                rf_raddr2 = dec.rs2;
            end
            ST_EXECUTE: begin
                case (dec.cls)
                    CLS_RTYPE: begin
                        alu_a       = op_a_q;
                        alu_b       = op_b_q;
                        alu_control = dec.alu_op;
                    end
                    CLS_LDI:  alu_a = DATA_WIDTH'(dec.imm);
                    CLS_BEQZ: begin
                        alu_a       = op_a_q;
                        alu_control = ALU_OR;
                    end
                    default: ;
                endcase
            end
            ST_WRITEBACK: begin
                if (dec.cls == CLS_RTYPE || dec.cls == CLS_LDI) begin
                    rf_we    = 1'b1;
                    rf_waddr = dec.rd;
                    rf_wdata = res_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with behavioural instruction memory, register file and ALU.
// Exercises the CTRL_ILLEGAL_TRAP_EN variant when that macro is defined.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic [7:0]  rf_rdata1, rf_rdata2, rf_wdata;
    logic        rf_we;
    logic [7:0]  alu_a, alu_b, alu_result;
    logic [2:0]  alu_control;
    logic        alu_zero;
    logic        zero_flag, halted, illegal;

    logic [15:0] imem [256];
    logic [7:0]  rf_model [8];
    int          wait_cnt = 0;
    int          imem_delay = 0;
    int          we_count = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .zero_flag   (zero_flag),
        .halted      (halted),
        .illegal     (illegal)
    );

    // Instruction memory answers after imem_delay wait cycles
    assign imem_rdata = imem[imem_addr];
    assign imem_valid = imem_req && (wait_cnt >= imem_delay);

    always @(posedge clk) begin
        if (imem_req && !imem_valid) wait_cnt <= wait_cnt + 1;
        else                         wait_cnt <= 0;
    end

    assign rf_rdata1 = rf_model[rf_raddr1];
    assign rf_rdata2 = rf_model[rf_raddr2];

    always @(posedge clk) begin
        if (rf_we) begin
            rf_model[rf_waddr] <= rf_wdata;
            we_count <= we_count + 1;
        end
    end

    always_comb begin
        case (alu_control)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b110:  alu_result = alu_a | alu_b;
            default: alu_result = 8'h00;
        endcase
    end
    assign alu_zero = (alu_result == 8'h00);

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
    endtask

    task automatic apply_stimulus_reset();
        reset = 1'b1;
        run   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Waits for a completed fetch and checks its address
    task automatic next_fetch(input string tag, input logic [7:0] exp_addr);
        logic [7:0] addr;
        addr = 'x;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (imem_req && imem_valid) begin
                addr = imem_addr;
                @(posedge clk);
                break;
            end
        end
        check_output(tag, {24'h0, addr}, {24'h0, exp_addr});
    endtask

    initial begin
        int we_snap;
        logic [7:0] held_addr;
        logic seen;

        $display("[TB] start");
        reset = 1'b1;
        run   = 1'b0;
        imem_delay = 0;
        clear_imem();

        // Test 1: reset state then LDI/LDI/SUB/HALT with zero-wait memory
        imem[0] = 16'h8205;
        imem[1] = 16'h8403;
        imem[2] = 16'h1650;
        imem[3] = 16'hF000;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_imem_req", imem_req, 0);
        check_output("rst_imem_addr", imem_addr, 0);
        check_output("rst_rf_we", rf_we, 0);
        check_output("rst_alu_control", alu_control, 0);
        check_output("rst_halted", halted, 0);
        check_output("rst_zero_flag", zero_flag, 0);
        check_output("rst_illegal", illegal, 0);
        @(negedge clk);
        reset = 1'b0;
        run   = 1'b1;
        we_snap = we_count;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            if (i == 1)  check_output("t1_fetch_req", imem_req, 1);
            if (i == 3)  check_output("t1_ldi_alu_a", alu_a, 8'h05);
            if (i == 11) begin
                check_output("t1_sub_ctrl", alu_control, 3'b001);
                check_output("t1_sub_a", alu_a, 8'h05);
                check_output("t1_sub_b", alu_b, 8'h03);
            end
            if (i == 12) check_output("t1_sub_wdata", rf_wdata, 8'h02);
            if (i == 14) check_output("t1_not_halted_yet", halted, 0);
            if (i == 15) check_output("t1_halted_at_15", halted, 1);
        end
        check_output("t1_halted", halted, 1);
        check_output("t1_r3", rf_model[3], 8'h02);
        check_output("t1_we_pulses", we_count - we_snap, 3);
        check_output("t1_zero_flag", zero_flag, 0);

        // Test 2: three wait cycles per fetch, request held stable
        apply_stimulus_reset();
        clear_imem();
        imem[0] = 16'h8209;
        imem[1] = 16'h8404;
        imem[2] = 16'h1850;
        imem[3] = 16'hF000;
        imem_delay = 3;
        we_snap = we_count;
        run = 1'b1;
        @(negedge clk);
        held_addr = imem_addr;
        check_output("t2_req_first", imem_req, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("t2_req_held", imem_req, 1);
            check_output("t2_addr_held", imem_addr, held_addr);
        end
        run = 1'b0;
        for (int i = 0; i < 100 && !halted; i++) @(negedge clk);
        check_output("t2_halted", halted, 1);
        check_output("t2_r4", rf_model[4], 8'h05);
        check_output("t2_we_pulses", we_count - we_snap, 3);

        // Test 3/4: BEQZ taken and not taken, JMP to 8'hFF then wrap to 8'h00
        apply_stimulus_reset();
        clear_imem();
        imem_delay = 0;
        imem[8'h00] = 16'h8200;
        imem[8'h01] = 16'h9240;
        imem[8'h40] = 16'h8201;
        imem[8'h41] = 16'h9280;
        imem[8'h42] = 16'hA0FF;
        imem[8'hFF] = 16'h8A07;
        run = 1'b1;
        next_fetch("t3_fetch0", 8'h00);
        next_fetch("t3_fetch1", 8'h01);
        check_output("t3_zero_after_ldi0", zero_flag, 1);
        next_fetch("t3_beqz_taken", 8'h40);
        next_fetch("t3_fetch41", 8'h41);
        check_output("t3_zero_after_ldi1", zero_flag, 0);
        next_fetch("t3_beqz_not_taken", 8'h42);
        next_fetch("t4_jmp_target", 8'hFF);
        next_fetch("t4_wrap", 8'h00);
        check_output("t4_r5", rf_model[5], 8'h07);

        // Test 5: illegal opcode 4'hC
        apply_stimulus_reset();
        clear_imem();
        imem[0] = 16'h8200;
        imem[1] = 16'hC000;
        imem[2] = 16'h8C11;
        run = 1'b1;
        next_fetch("t5_fetch0", 8'h00);
        next_fetch("t5_fetch1", 8'h01);
        we_snap = we_count;
`ifdef CTRL_ILLEGAL_TRAP_EN
        repeat (6) @(negedge clk);
        check_output("t5_trap_halted", halted, 1);
        check_output("t5_trap_illegal", illegal, 1);
        check_output("t5_trap_no_we", we_count - we_snap, 0);
`else
        next_fetch("t5_nop_pc_inc", 8'h02);
        check_output("t5_nop_zero_kept", zero_flag, 1);
        check_output("t5_nop_illegal", illegal, 0);
        check_output("t5_nop_no_we", we_count - we_snap, 0);
`endif

        // Test 6: reset asserted during WRITEBACK
        apply_stimulus_reset();
        clear_imem();
        imem[0] = 16'h8E33;
        run = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rf_we) begin
                seen = 1'b1;
                break;
            end
        end
        check_output("t6_reached_wb", seen, 1);
        we_snap = we_count;
        reset = 1'b1;
        #1;
        check_output("t6_rf_we_dropped", rf_we, 0);
        check_output("t6_imem_addr", imem_addr, 0);
        check_output("t6_imem_req", imem_req, 0);
        @(posedge clk);
        #1;
        check_output("t6_no_write", we_count - we_snap, 0);
        check_output("t6_idle_req", imem_req, 0);
        @(negedge clk);
        reset = 1'b0;
        next_fetch("t6_restart_fetch", 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
